sample_walker: RTL and testbench

SAMPLE_WALKER -- requirements
Module: sample_walker

---
 rtl/sample_walker_if.sv | 30 +++
 rtl/sample_walker.sv | 153 +++++++++++++++
 tb/tb_sample_walker.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sample_walker_if.sv
// Triangle-in / sample-out bundle between the setup stage, the sample walker
// and the downstream sample tester.
interface sample_walker_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R15S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_R15U;
    logic signed [1:0][1:0][SIGFIG-1:0]            box_R15S;
    logic        [3:0]                             subSample_R15U;
    logic                                          validTri_R15H;
    logic                                          halt_R15L;

    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_R16U;
    logic signed [1:0][SIGFIG-1:0]                 sample_R16S;
    logic                                          validSamp_R16H;

    modport master (
        output tri_R15S, color_R15U, box_R15S, subSample_R15U, validTri_R15H,
        input  halt_R15L, tri_R16S, color_R16U, sample_R16S, validSamp_R16H
    );

    modport slave (
        input  tri_R15S, color_R15U, box_R15S, subSample_R15U, validTri_R15H,
        output halt_R15L, tri_R16S, color_R16U, sample_R16S, validSamp_R16H
    );
endinterface

// File: rtl/sample_walker.sv
// Walks the sample grid of a triangle's bounding box in raster order, one
// sample per cycle, holding the triangle and color steady for the walk.
module sample_walker #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input logic            clk,
    input logic            rst,
    sample_walker_if.slave bus
);
    localparam int CW = SIGFIG + 1;

    typedef logic signed [CW-1:0] coord_t;
    typedef enum logic {WAIT, TEST} state_t;

    function automatic coord_t widen(input logic [SIGFIG-1:0] v);
        return {v[SIGFIG-1], v};
    endfunction

    // One extra bit keeps x+step / y+step from wrapping near the top of the range.
    function automatic logic is_last(input coord_t x, input coord_t y, input coord_t step,
                                     input coord_t urx, input coord_t ury);
        return ((x + step) > urx) && ((y + step) > ury);
    endfunction

    function automatic coord_t step_of(input logic [3:0] sub);
        int shift;
        case (sub)
            4'b0100: shift = RADIX - 1;
            4'b0010: shift = RADIX - 2;
            4'b0001: shift = RADIX - 3;
            default: shift = RADIX;
        endcase
        return coord_t'(1) << shift;
    endfunction

    state_t                                        state_q;
    logic                                          halt_q;
    logic                                          vld_q;
    logic        [SIGFIG-1:0]                      sx_q, sy_q;
    logic        [SIGFIG-1:0]                      llx_q, lly_q, urx_q, ury_q;
    coord_t                                        step_q;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_q;

    logic   accept;
    logic   last_c, walk_last, first_last, nonempty;
    coord_t x_c, y_c, x_adv, y_adv, x_w, y_w;
    coord_t llx_c, urx_c, ury_c;
    coord_t nllx, nlly, nurx, nury, nstep;

    always_comb begin
        accept = bus.validTri_R15H && halt_q;

        x_c   = widen(sx_q);
        y_c   = widen(sy_q);
        llx_c = widen(llx_q);
        urx_c = widen(urx_q);
        ury_c = widen(ury_q);
        x_adv = x_c + step_q;
        y_adv = y_c + step_q;

        if (x_adv <= urx_c) begin
            x_w = x_adv;
            y_w = y_c;
        end else begin
            x_w = llx_c;
            y_w = y_adv;
        end

        last_c    = is_last(x_c, y_c, step_q, urx_c, ury_c);
        walk_last = is_last(x_w, y_w, step_q, urx_c, ury_c);

        nllx       = widen(bus.box_R15S[0][0]);
        nlly       = widen(bus.box_R15S[0][1]);
        nurx       = widen(bus.box_R15S[1][0]);
        nury       = widen(bus.box_R15S[1][1]);
        nstep      = step_of(bus.subSample_R15U);
        nonempty   = (nllx <= nurx) && (nlly <= nury);
        first_last = is_last(nllx, nlly, nstep, nurx, nury);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            halt_q  <= 1'b1;
            vld_q   <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
            llx_q   <= '0;
            lly_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            step_q  <= '0;
            tri_q   <= '0;
            color_q <= '0;
        end else if (accept) begin
            tri_q   <= bus.tri_R15S;
            color_q <= bus.color_R15U;
            llx_q   <= bus.box_R15S[0][0];
            lly_q   <= bus.box_R15S[0][1];
            urx_q   <= bus.box_R15S[1][0];
            ury_q   <= bus.box_R15S[1][1];
            step_q  <= nstep;
            if (nonempty) begin
                state_q <= TEST;
                vld_q   <= 1'b1;
                sx_q    <= bus.box_R15S[0][0];
                sy_q    <= bus.box_R15S[0][1];
                halt_q  <= first_last;
            end else begin
                // Empty box: the triangle covers no samples and is dropped.
                state_q <= WAIT;
                vld_q   <= 1'b0;
                halt_q  <= 1'b1;
            end
        end else begin
            case (state_q)
                TEST: begin
                    if (last_c) begin
                        state_q <= WAIT;
                        vld_q   <= 1'b0;
                        halt_q  <= 1'b1;
                    end else begin
                        vld_q  <= 1'b1;
                        sx_q   <= x_w[SIGFIG-1:0];
                        sy_q   <= y_w[SIGFIG-1:0];
                        halt_q <= walk_last;
                    end
                end
                WAIT: begin
                    vld_q  <= 1'b0;
                    halt_q <= 1'b1;
                end
                default: begin
                    state_q <= WAIT;
                    vld_q   <= 1'b0;
                    halt_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.halt_R15L      = halt_q;
    assign bus.validSamp_R16H = vld_q;
    assign bus.sample_R16S[0] = sx_q;
    assign bus.sample_R16S[1] = sy_q;
    assign bus.tri_R16S       = tri_q;
    assign bus.color_R16U     = color_q;
endmodule

// File: tb/tb_sample_walker.sv
// Self-checking bench for sample_walker: table of boxes plus hand-written
// reset, back-to-back and mid-walk reset sequences, checked via a scoreboard.
module tb_sample_walker;
    localparam int SIGFIG = 24;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int TW     = VERTS * AXIS * SIGFIG;
    localparam int CLW    = COLORS * SIGFIG;

    typedef struct {
        logic signed [SIGFIG-1:0] x;
        logic signed [SIGFIG-1:0] y;
        logic                     halt;
        logic [TW-1:0]            tri_v;
        logic [CLW-1:0]           col;
    } exp_t;

    typedef struct {
        int         llx, lly, urx, ury;
        logic [3:0] sub;
        int         exp_n;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total = 0;
    int   seen_cnt = 0;
    exp_t sb[$];
    vec_t vecs[8];

    sample_walker_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

    sample_walker #(.SIGFIG(SIGFIG), .RADIX(10), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [TW-1:0] make_tri(input int tag);
        logic [TW-1:0] v;
        for (int w = 0; w < VERTS * AXIS; w++) v[w*SIGFIG +: SIGFIG] = SIGFIG'(tag * 16 + w + 1);
        return v;
    endfunction

    function automatic logic [CLW-1:0] make_col(input int tag);
        logic [CLW-1:0] v;
        for (int c = 0; c < COLORS; c++) v[c*SIGFIG +: SIGFIG] = SIGFIG'(tag * 256 + c + 'h10);
        return v;
    endfunction

    function automatic int bstep(input logic [3:0] sub);
        case (sub)
            4'b1000: return 1024;
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %0d required %0d", nm, act, req);
        else passed++;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.validSamp_R16H === 1'b1) begin
            seen_cnt++;
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_sample: got x=%0d y=%0d required no sample",
                         $signed(bus.sample_R16S[0]), $signed(bus.sample_R16S[1]));
            end else begin
                e = sb.pop_front();
                if (bus.sample_R16S[0] !== e.x || bus.sample_R16S[1] !== e.y ||
                    bus.halt_R15L !== e.halt || bus.tri_R16S !== e.tri_v || bus.color_R16U !== e.col)
                    $display("FAIL sample: got x=%0d y=%0d halt=%0b tri=%h col=%h required x=%0d y=%0d halt=%0b tri=%h col=%h",
                             $signed(bus.sample_R16S[0]), $signed(bus.sample_R16S[1]), bus.halt_R15L,
                             bus.tri_R16S, bus.color_R16U, e.x, e.y, e.halt, e.tri_v, e.col);
                else
                    passed++;
            end
        end
    end

    task automatic set_inputs(input int i, input int tag);
        bus.tri_R15S       = make_tri(tag);
        bus.color_R15U     = make_col(tag);
        bus.box_R15S[0][0] = SIGFIG'(vecs[i].llx);
        bus.box_R15S[0][1] = SIGFIG'(vecs[i].lly);
        bus.box_R15S[1][0] = SIGFIG'(vecs[i].urx);
        bus.box_R15S[1][1] = SIGFIG'(vecs[i].ury);
        bus.subSample_R15U = vecs[i].sub;
    endtask

    // Waits for halt high, presents the triangle for one accept edge, queues its samples.
    task automatic drive_accept(input int i, input int tag);
        int   n, st, nx, ny;
        vec_t v;
        exp_t e;
        v = vecs[i];
        n = 0;
        @(negedge clk);
        while (bus.halt_R15L !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.halt_R15L !== 1'b1) begin
            total++;
            $display("FAIL accept_timeout vec %0d: halt_R15L=%0b required 1", i, bus.halt_R15L);
            return;
        end
        set_inputs(i, tag);
        bus.validTri_R15H = 1'b1;
        st = bstep(v.sub);
        if (v.llx <= v.urx && v.lly <= v.ury) begin
            nx = (v.urx - v.llx) / st + 1;
            ny = (v.ury - v.lly) / st + 1;
            for (int j = 0; j < ny; j++) begin
                for (int k = 0; k < nx; k++) begin
                    e.x     = SIGFIG'(v.llx + k * st);
                    e.y     = SIGFIG'(v.lly + j * st);
                    e.halt  = (k == nx - 1) && (j == ny - 1);
                    e.tri_v = make_tri(tag);
                    e.col   = make_col(tag);
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1 bus.validTri_R15H = 1'b0;
    endtask

    task automatic run_tri(input int i, input int tag);
        int s0;
        s0 = seen_cnt;
        drive_accept(i, tag);
        if (vecs[i].exp_n == 0) begin
            repeat (3) begin
                chk("empty_halt", 64'(bus.halt_R15L), 1);
                chk("empty_vld", 64'(bus.validSamp_R16H), 0);
                @(posedge clk);
                #1;
            end
        end else begin
            repeat (vecs[i].exp_n) @(posedge clk);
            #1;
        end
        chk("end_vld", 64'(bus.validSamp_R16H), 0);
        chk("end_halt", 64'(bus.halt_R15L), 1);
        chk("sb_drained", 64'(sb.size()), 0);
        chk("sample_count", 64'(seen_cnt - s0), 64'(vecs[i].exp_n));
    endtask

    initial begin
        int s0;
        vecs[0] = '{0, 0, 2048, 1024, 4'b1000, 6};
        vecs[1] = '{512, 512, 512, 512, 4'b0100, 1};
        vecs[2] = '{0, 0, 512, 512, 4'b0100, 4};
        vecs[3] = '{1024, 0, 0, 0, 4'b1000, 0};
        vecs[4] = '{-1024, -512, 1024, 512, 4'b0010, 45};
        vecs[5] = '{0, 0, 256, 128, 4'b0001, 6};
        vecs[6] = '{0, 0, 1024, 0, 4'b0110, 2};
        vecs[7] = '{0, 1024, 0, 0, 4'b1000, 0};

        rst = 1'b1;
        set_inputs(0, 5);
        bus.validTri_R15H = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 64'(bus.validSamp_R16H), 0);
        chk("rst_halt", 64'(bus.halt_R15L), 1);
        chk("rst_sample", 64'(bus.sample_R16S), 0);
        chk("rst_tri", 64'(|bus.tri_R16S), 0);
        chk("rst_col", 64'(|bus.color_R16U), 0);
        rst = 1'b0;
        bus.validTri_R15H = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle", 64'(bus.validSamp_R16H), 0);
        end

        for (int i = 0; i < 8; i++) run_tri(i, i + 1);

        // Second triangle presented on the first one's last-sample cycle.
        s0 = seen_cnt;
        drive_accept(0, 20);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_last_vld", 64'(bus.validSamp_R16H), 1);
        chk("b2b_last_halt", 64'(bus.halt_R15L), 1);
        drive_accept(2, 21);
        chk("b2b_no_bubble", 64'(bus.validSamp_R16H), 1);
        chk("b2b_tri_switch", 64'(bus.tri_R16S == make_tri(21)), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_end_vld", 64'(bus.validSamp_R16H), 0);
        chk("b2b_sb_drained", 64'(sb.size()), 0);
        chk("b2b_count", 64'(seen_cnt - s0), 10);

        // Reset while the third of six samples is on the outputs.
        drive_accept(0, 30);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_vld", 64'(bus.validSamp_R16H), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_vld", 64'(bus.validSamp_R16H), 0);
        chk("mid_rst_halt", 64'(bus.halt_R15L), 1);
        chk("mid_rst_left", 64'(sb.size()), 3);
        sb.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("mid_rst_idle", 64'(bus.validSamp_R16H), 0);
        end
        run_tri(0, 31);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
